// File: rtl/seq_pkg.sv
// ============================================================================
// Package : seq_pkg
// Purpose : State encodings for the pipeline sequencer and opcode constants
//           shared with the decode control unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2,
        ST_STEP   = 2'd3
    } seq_state_e;

    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_HALT = 6'b111111;

endpackage : seq_pkg

`default_nettype wire

// File: rtl/hazard_detect.sv
// ============================================================================
// Module  : hazard_detect
// Purpose : Combinational load-use compare between the load in EX and the
//           source registers of the instruction in ID.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detect (
    input  logic       ex_memtoreg_i,
    input  logic [4:0] ex_rt_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    output logic       load_use_o
);

    // $zero never carries a real dependency, so a load targeting it never stalls.
    assign load_use_o = ex_memtoreg_i && (ex_rt_i != 5'd0) &&
                        ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

endmodule : hazard_detect

`default_nettype wire

// File: rtl/pipeline_sequencer.sv
// ============================================================================
// Module  : pipeline_sequencer
// Purpose : Run/drain/halt sequencing and per-stage enables/flushes for the
//           5-stage pipeline; optional single-step debug with DEBUG_STEP_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_sequencer
    import seq_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       id_op,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_halt,
    input  logic             ex_memtoreg,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
`ifdef DEBUG_STEP_EN
    input  logic             step_req,
    input  logic             resume_req,
`endif
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    seq_state_e         state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [CNT_W-1:0]   cycle_q;
    logic               halted_q;
    logic               load_use;

    hazard_detect u_hazard_detect (
        .ex_memtoreg_i (ex_memtoreg),
        .ex_rt_i       (ex_rt),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_uses_rt_i  (id_uses_rt),
        .load_use_o    (load_use)
    );

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        ex_mem_en   = 1'b1;
        case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    ex_mem_en = 1'b0;
                end else if (ex_branch_taken) begin
                    // ID holds a wrong-path instruction; any HALT or stall it asks for is void.
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end else if (id_halt) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                    drain_d     = DRAIN_W'(DRAIN_CYCLES);
                    state_d     = ST_DRAIN;
                end else if (id_op == OP_J) begin
                    if_id_flush = 1'b1;
                end
            end
            ST_DRAIN: begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
                ex_mem_en   = !mem_busy;
                if (!mem_busy) begin
                    if (drain_q == DRAIN_W'(1)) begin
                        drain_d = '0;
                        state_d = ST_HALTED;
                    end else begin
                        drain_d = drain_q - DRAIN_W'(1);
                    end
                end
            end
            ST_HALTED: begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                ex_mem_en   = 1'b0;
                id_ex_flush = 1'b1;
`ifdef DEBUG_STEP_EN
                // The PC already points past the held HALT, so dropping IF/ID is enough.
                if (resume_req) begin
                    if_id_flush = 1'b1;
                    state_d     = ST_RUN;
                end else if (step_req) begin
                    state_d = ST_STEP;
                end
`endif
            end
            default: begin
                if (mem_busy) begin
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    ex_mem_en = 1'b0;
                end else begin
                    state_d = ST_HALTED;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            drain_q  <= '0;
            cycle_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            halted_q <= (state_d == ST_HALTED);
            if ((state_q != ST_HALTED) && (cycle_q != {CNT_W{1'b1}})) begin
                cycle_q <= cycle_q + CNT_W'(1);
            end
        end
    end

    assign halted      = halted_q;
    assign cycle_count = cycle_q;

endmodule : pipeline_sequencer

`default_nettype wire
